// File: rtl/fetch_stage.sv
// RV64 instruction-fetch stage: owns the PC, talks to IMEM over req/ready,
// and fills the DE latch for decode.
module fetch_stage #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter logic [31:0] NOP_IR   = 32'h00000013
) (
  input  logic        CLK,
  input  logic        reset,
  output logic        IMEM_REQ,
  output logic [63:0] IMEM_ADDR,
  input  logic        IMEM_RDY,
  input  logic [31:0] IMEM_DATA,
  input  logic        LD_DE,
  input  logic        BR_STALL,
  input  logic        BR_RESOLVE,
  input  logic        BR_TAKEN,
  input  logic [63:0] BR_TARGET,
  input  logic        TRAP,
  input  logic [63:0] DE_MTVEC,
  output logic [31:0] DE_IR,
  output logic [63:0] DE_NPC,
  output logic        DE_V,
  output logic [63:0] FE_PC
);

  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] HOLD  = 2'd1;
  localparam logic [1:0] STALL = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]  state, state_n;
  logic [63:0] pc, pc_n;
  logic [63:0] addr, addr_n;
  logic [31:0] buf_ir, buf_n;
  logic [31:0] de_ir_n;
  logic [63:0] de_npc_n;
  logic        de_v_n;
  logic        busy;
  logic        pend;
  logic [63:0] pc_inc;
  logic [63:0] redir;

  assign busy      = (state == FETCH) || (state == DRAIN);
  assign pend      = busy && !IMEM_RDY;
  assign pc_inc    = pc + 64'd4;
  assign IMEM_REQ  = reset && busy;
  assign IMEM_ADDR = addr;
  assign FE_PC     = pc;

  // Next-state: trap beats resolve beats stall beats normal fetch
  always_comb begin
    state_n  = state;
    pc_n     = pc;
    addr_n   = addr;
    buf_n    = buf_ir;
    de_ir_n  = DE_IR;
    de_npc_n = DE_NPC;
    de_v_n   = DE_V;
    redir    = pc;
    if (TRAP) begin
      redir   = {DE_MTVEC[63:2], 2'b00};
      pc_n    = redir;
      addr_n  = pend ? addr : redir;
      state_n = pend ? DRAIN : FETCH;
      de_v_n  = 1'b0;
    end else if (BR_RESOLVE) begin
      redir   = BR_TAKEN ? {BR_TARGET[63:2], 2'b00} : pc;
      pc_n    = redir;
      addr_n  = pend ? addr : redir;
      state_n = pend ? DRAIN : FETCH;
      if (LD_DE) de_v_n = 1'b0;
    end else if (BR_STALL) begin
      if (LD_DE) de_v_n = 1'b0;
      unique case (state)
        FETCH: state_n = IMEM_RDY ? STALL : DRAIN;
        HOLD:  state_n = STALL;
        DRAIN: begin
          if (IMEM_RDY) begin
            addr_n  = pc;
            state_n = STALL;
          end
        end
        default: state_n = STALL;
      endcase
    end else begin
      if (LD_DE) de_v_n = 1'b0;
      unique case (state)
        FETCH: begin
          if (IMEM_RDY && LD_DE) begin
            de_ir_n  = IMEM_DATA;
            de_npc_n = pc_inc;
            de_v_n   = 1'b1;
            pc_n     = pc_inc;
            addr_n   = pc_inc;
          end else if (IMEM_RDY) begin
            buf_n   = IMEM_DATA;
            state_n = HOLD;
          end
        end
        HOLD: begin
          if (LD_DE) begin
            de_ir_n  = buf_ir;
            de_npc_n = pc_inc;
            de_v_n   = 1'b1;
            pc_n     = pc_inc;
            addr_n   = pc_inc;
            state_n  = FETCH;
          end
        end
        DRAIN: begin
          if (IMEM_RDY) begin
            addr_n  = pc;
            state_n = FETCH;
          end
        end
        default: state_n = STALL;
      endcase
    end
  end

  // State, PC, request address, buffer and DE latch registers
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state  <= FETCH;
      pc     <= RESET_PC;
      addr   <= RESET_PC;
      buf_ir <= NOP_IR;
      DE_IR  <= NOP_IR;
      DE_NPC <= 64'h0;
      DE_V   <= 1'b0;
    end else begin
      state  <= state_n;
      pc     <= pc_n;
      addr   <= addr_n;
      buf_ir <= buf_n;
      DE_IR  <= de_ir_n;
      DE_NPC <= de_npc_n;
      DE_V   <= de_v_n;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: vector table with a DE-latch scoreboard,
// then a hand-written mid-operation reset sequence.
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        reset;
  logic        IMEM_REQ;
  logic [63:0] IMEM_ADDR;
  logic        IMEM_RDY;
  logic [31:0] IMEM_DATA;
  logic        LD_DE;
  logic        BR_STALL;
  logic        BR_RESOLVE;
  logic        BR_TAKEN;
  logic [63:0] BR_TARGET;
  logic        TRAP;
  logic [63:0] DE_MTVEC;
  logic [31:0] DE_IR;
  logic [63:0] DE_NPC;
  logic        DE_V;
  logic [63:0] FE_PC;

  always #5 CLK = ~CLK;

  fetch_stage dut (
    .CLK(CLK), .reset(reset),
    .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR),
    .IMEM_RDY(IMEM_RDY), .IMEM_DATA(IMEM_DATA),
    .LD_DE(LD_DE), .BR_STALL(BR_STALL),
    .BR_RESOLVE(BR_RESOLVE), .BR_TAKEN(BR_TAKEN),
    .BR_TARGET(BR_TARGET), .TRAP(TRAP),
    .DE_MTVEC(DE_MTVEC), .DE_IR(DE_IR),
    .DE_NPC(DE_NPC), .DE_V(DE_V), .FE_PC(FE_PC)
  );

  function automatic logic [31:0] mem(input logic [63:0] a);
    return a[31:0] ^ 32'h5A5A_0013;
  endfunction

  assign IMEM_DATA = mem(IMEM_ADDR);

  typedef struct {
    logic        rdy, ld, stall, res, taken;
    logic [63:0] tgt;
    logic        trap;
    logic [63:0] mtvec;
    logic        ereq;
    logic [63:0] eaddr;
    logic        ev, enew;
    logic [63:0] enpc;
  } vec_t;

  typedef struct {
    logic [31:0] ir;
    logic [63:0] npc;
  } de_t;

  vec_t tv[$];
  de_t  sb[$];
  int   passed = 0;
  int   total  = 0;

  function automatic void add(
    input logic rdy, ld, stall, res, taken,
    input logic [63:0] tgt,
    input logic trap,
    input logic [63:0] mtvec,
    input logic ereq,
    input logic [63:0] eaddr,
    input logic ev, enew,
    input logic [63:0] enpc);
    vec_t v;
    v.rdy = rdy; v.ld = ld; v.stall = stall;
    v.res = res; v.taken = taken; v.tgt = tgt;
    v.trap = trap; v.mtvec = mtvec;
    v.ereq = ereq; v.eaddr = eaddr;
    v.ev = ev; v.enew = enew; v.enpc = enpc;
    tv.push_back(v);
  endfunction

  function automatic void fetch(input logic [63:0] a);
    add(1, 1, 0, 0, 0, 0, 0, 0, 1, a, 1, 1, a + 64'd4);
  endfunction

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic drive_idle();
    IMEM_RDY = 0; LD_DE = 0; BR_STALL = 0;
    BR_RESOLVE = 0; BR_TAKEN = 0; BR_TARGET = 0;
    TRAP = 0; DE_MTVEC = 0;
  endtask

  initial begin
    de_t d;
    reset = 1'b0;
    drive_idle();

    for (logic [63:0] a = 0; a < 64'h10; a += 4) fetch(a);
    repeat (3) add(0, 1, 0, 0, 0, 0, 0, 0, 1, 'h10, 0, 0, 0);
    for (logic [63:0] a = 'h10; a < 64'h20; a += 4) fetch(a);
    add(1, 0, 0, 0, 0, 0, 0, 0, 1, 'h20, 1, 0, 'h20);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 'h20);
    add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'h24);
    for (logic [63:0] a = 'h24; a < 64'h40; a += 4) fetch(a);
    add(1, 1, 1, 0, 0, 0, 0, 0, 1, 'h40, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 1, 1, 'h103, 0, 0, 0, 0, 0, 0, 0);
    fetch('h100);
    add(1, 1, 1, 0, 0, 0, 0, 0, 1, 'h104, 0, 0, 0);
    add(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    fetch('h104);
    add(0, 1, 1, 0, 0, 0, 0, 0, 1, 'h108, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, 0, 0, 1, 'h108, 0, 0, 0);
    add(1, 1, 1, 0, 0, 0, 0, 0, 1, 'h108, 0, 0, 0);
    add(0, 1, 0, 1, 1, 'h80, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 1, 'h8001, 1, 'h80, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 1, 'h80, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0, 1, 'h80, 0, 0, 0);
    fetch('h8000);
    add(0, 1, 0, 1, 1, 'h200, 0, 0, 1, 'h8004, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0, 1, 'h8004, 0, 0, 0);
    fetch('h200);
    add(1, 1, 0, 1, 1, 'h400, 1, 'h300, 1, 'h204, 0, 0, 0);
    fetch('h300);
    add(1, 1, 0, 0, 0, 0, 1, '1, 1, 'h304, 0, 0, 0);
    fetch(64'hFFFF_FFFF_FFFF_FFFC);
    add(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);

    repeat (2) @(negedge CLK);
    chk("rst_req", IMEM_REQ, 0);
    chk("rst_addr", IMEM_ADDR, 0);
    chk("rst_pc", FE_PC, 0);
    chk("rst_ir", DE_IR, 32'h13);
    chk("rst_npc", DE_NPC, 0);
    chk("rst_v", DE_V, 0);
    reset = 1'b1;
    #1;
    chk("first_req", IMEM_REQ, 1);
    chk("first_addr", IMEM_ADDR, 0);

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge CLK);
      IMEM_RDY   = tv[i].rdy;
      LD_DE      = tv[i].ld;
      BR_STALL   = tv[i].stall;
      BR_RESOLVE = tv[i].res;
      BR_TAKEN   = tv[i].taken;
      BR_TARGET  = tv[i].tgt;
      TRAP       = tv[i].trap;
      DE_MTVEC   = tv[i].mtvec;
      if (tv[i].enew) begin
        d.ir  = mem(tv[i].enpc - 64'd4);
        d.npc = tv[i].enpc;
        sb.push_back(d);
      end
      #1;
      chk($sformatf("req[%0d]", i), IMEM_REQ, tv[i].ereq);
      if (tv[i].ereq)
        chk($sformatf("addr[%0d]", i), IMEM_ADDR, tv[i].eaddr);
      @(posedge CLK);
      #1;
      chk($sformatf("de_v[%0d]", i), DE_V, tv[i].ev);
      if (tv[i].ev)
        chk($sformatf("de_npc[%0d]", i), DE_NPC, tv[i].enpc);
      if (tv[i].enew) begin
        if (sb.size() > 0) begin
          d = sb.pop_front();
          chk($sformatf("sb_ir[%0d]", i), DE_IR, d.ir);
          chk($sformatf("sb_npc[%0d]", i), DE_NPC, d.npc);
        end else begin
          total++;
          $display("FAIL sb_empty[%0d]: got 0 entries want 1", i);
        end
      end
    end
    chk("sb_drained", sb.size(), 0);

    @(negedge CLK);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_req", IMEM_REQ, 0);
    chk("mid_rst_v", DE_V, 0);
    chk("mid_rst_ir", DE_IR, 32'h13);
    chk("mid_rst_pc", FE_PC, 0);
    @(negedge CLK);
    reset = 1'b1;
    drive_idle();
    IMEM_RDY = 1;
    LD_DE    = 1;
    #1;
    chk("rel_req", IMEM_REQ, 1);
    chk("rel_addr", IMEM_ADDR, 0);
    @(posedge CLK);
    #1;
    chk("rel_v", DE_V, 1);
    chk("rel_ir", DE_IR, mem(0));
    chk("rel_npc", DE_NPC, 4);
    chk("rel_next", IMEM_ADDR, 4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
